// File: rtl/rf_pkg.sv
// Shared types and helpers for the two-read/one-write register file.
// Holds the clear-engine state type and the address-width rule.
package rf_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bulk-clear engine: walks the array zeroing one entry per cycle.
// busy is registered and stays high for exactly DEPTH cycles per clear.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RF_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // clr_req is deliberately ignored here: a running clear is never restarted.
                    if (cnt == LAST) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one byte-masked write port, two registered read ports,
// optional write-to-read bypass, optional zero entry, range checking and bulk clear.
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = rf_aw(DEPTH),
    localparam int BW       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [BW-1:0]    wr_be,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             addr_err
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             wr_fire;
    logic             err_now;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    function automatic logic [WIDTH-1:0] read_mux(input logic [AW-1:0]    a,
                                                  input logic [WIDTH-1:0] stored,
                                                  input logic             hit,
                                                  input logic [WIDTH-1:0] merged);
        if (!in_range(a) || (ZERO_REG != 0 && a == '0)) return '0;
        if (BYPASS != 0 && hit) return merged;
        return stored;
    endfunction

    rf_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        wr_word = mem[wr_addr];
        for (int i = 0; i < BW; i++) begin
            if (wr_be[i]) wr_word[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    assign wr_fire = wr_en && !busy && in_range(wr_addr) && !(ZERO_REG != 0 && wr_addr == '0);
    assign err_now = (wr_en && !in_range(wr_addr)) || (rd_en_a && !in_range(rd_addr_a))
                  || (rd_en_b && !in_range(rd_addr_b));

    assign next_a = read_mux(rd_addr_a, mem[rd_addr_a], wr_fire && (rd_addr_a == wr_addr), wr_word);
    assign next_b = read_mux(rd_addr_b, mem[rd_addr_b], wr_fire && (rd_addr_b == wr_addr), wr_word);

    // NOTE: the array is built from flops precisely so that reset can zero every entry; a RAM macro could not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= next_a;
            if (rd_en_b) rd_data_b <= next_b;
            addr_err <= err_now;
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances (8-deep bypass, 6-deep no-bypass zero-reg)
// share one stimulus stream and are compared against an array-based reference model.
module tb_reg_file_2r1w;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en_a;
    logic [2:0]  rd_addr_a;
    logic        rd_en_b;
    logic [2:0]  rd_addr_b;
    logic        clr_req;

    logic [15:0] rd_data_a [NDUT];
    logic [15:0] rd_data_b [NDUT];
    logic        rd_valid_a [NDUT];
    logic        rd_valid_b [NDUT];
    logic        busy [NDUT];
    logic        addr_err [NDUT];

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a[0]), .rd_valid_a(rd_valid_a[0]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b[0]), .rd_valid_b(rd_valid_b[0]),
        .clr_req(clr_req), .busy(busy[0]), .addr_err(addr_err[0])
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a[1]), .rd_valid_a(rd_valid_a[1]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b[1]), .rd_valid_b(rd_valid_b[1]),
        .clr_req(clr_req), .busy(busy[1]), .addr_err(addr_err[1])
    );

    // Reference model state, one copy per instance.
    int          p_depth [NDUT] = '{8, 6};
    int          p_byp   [NDUT] = '{1, 0};
    int          p_zr    [NDUT] = '{0, 1};
    logic [15:0] m_mem [NDUT][8];
    int          m_pos [NDUT];     // entry being cleared next, -1 when no clear runs
    logic [15:0] e_da [NDUT];
    logic [15:0] e_db [NDUT];
    logic        e_va [NDUT];
    logic        e_vb [NDUT];
    logic        e_busy [NDUT];
    logic        e_err [NDUT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic [1:0]  wr_be;
        logic        rd_en_a;
        logic [2:0]  rd_addr_a;
        logic        rd_en_b;
        logic [2:0]  rd_addr_b;
        logic        exp_va;
        logic        exp_vb;
        logic [15:0] exp_a0;
        logic [15:0] exp_b0;
        logic [15:0] exp_a1;
        logic [15:0] exp_b1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] data, input logic [1:0] be);
        return {be[1] ? data[15:8] : old[15:8], be[0] ? data[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] model_read(input int d, input int a, input logic hit, input logic [15:0] nw);
        if (a >= p_depth[d] || (p_zr[d] == 1 && a == 0)) return 16'h0000;
        if (p_byp[d] == 1 && hit) return nw;
        return m_mem[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) m_mem[d][i] = 16'h0000;
            m_pos[d]  = -1;
            e_da[d]   = '0;
            e_db[d]   = '0;
            e_va[d]   = 1'b0;
            e_vb[d]   = 1'b0;
            e_busy[d] = 1'b0;
            e_err[d]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            int          dep = p_depth[d];
            bit          bsy = (m_pos[d] >= 0);
            int          wa  = int'(wr_addr);
            int          ra  = int'(rd_addr_a);
            int          rb  = int'(rd_addr_b);
            bit          wr_ok;
            logic [15:0] nw;
            wr_ok = wr_en && !bsy && wa < dep && !(p_zr[d] == 1 && wa == 0);
            nw    = merge(m_mem[d][wa], wr_data, wr_be);
            e_va[d] = rd_en_a;
            e_vb[d] = rd_en_b;
            if (rd_en_a) e_da[d] = model_read(d, ra, wr_ok && ra == wa, nw);
            if (rd_en_b) e_db[d] = model_read(d, rb, wr_ok && rb == wa, nw);
            e_err[d] = (wr_en && wa >= dep) || (rd_en_a && ra >= dep) || (rd_en_b && rb >= dep);
            if (bsy) begin
                m_mem[d][m_pos[d]] = 16'h0000;
                m_pos[d]++;
                if (m_pos[d] == dep) m_pos[d] = -1;
            end else begin
                if (wr_ok) m_mem[d][wa] = nw;
                if (clr_req) m_pos[d] = 0;
            end
            e_busy[d] = (m_pos[d] >= 0);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d.rd_data_a", d), 32'(rd_data_a[d]), 32'(e_da[d]));
            check($sformatf("d%0d.rd_valid_a", d), 32'(rd_valid_a[d]), 32'(e_va[d]));
            check($sformatf("d%0d.rd_data_b", d), 32'(rd_data_b[d]), 32'(e_db[d]));
            check($sformatf("d%0d.rd_valid_b", d), 32'(rd_valid_b[d]), 32'(e_vb[d]));
            check($sformatf("d%0d.busy", d), 32'(busy[d]), 32'(e_busy[d]));
            check($sformatf("d%0d.addr_err", d), 32'(addr_err[d]), 32'(e_err[d]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
        clr_req = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [15:0] data);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = data; wr_be = 2'b11;
        cycle();
    endtask

    task automatic do_read(input int a);
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 3'(a); rd_en_b = 1'b1; rd_addr_b = 3'(a);
        cycle();
    endtask

    initial begin
        int busy_cnt [NDUT];

        vecs[0] = '{1'b1, 3'd0, 16'd50,    2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0,    16'd0,    16'd0,    16'd0};
        vecs[1] = '{1'b1, 3'd2, 16'd93,    2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0,    16'd0,    16'd0,    16'd0};
        vecs[2] = '{1'b0, 3'd0, 16'd0,     2'b00, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 1'b1, 16'd50,   16'd93,   16'd0,    16'd93};
        vecs[3] = '{1'b1, 3'd3, 16'hABCD,  2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd50,   16'd93,   16'd0,    16'd93};
        vecs[4] = '{1'b1, 3'd3, 16'h1200,  2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd50,   16'd93,   16'd0,    16'd93};
        vecs[5] = '{1'b0, 3'd0, 16'd0,     2'b00, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 16'h12CD, 16'd93,   16'h12CD, 16'd93};
        vecs[6] = '{1'b1, 3'd5, 16'h7777,  2'b11, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 16'h7777, 16'h7777, 16'd0,    16'd0};
        vecs[7] = '{1'b0, 3'd0, 16'd0,     2'b00, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 1'b0, 16'h7777, 16'h7777, 16'h7777, 16'd0};

        idle_inputs();
        rst = 1'b0;
        model_reset();
        #12;
        check_outputs();
        rst = 1'b1;

        // Directed vectors: basic reads, byte lanes, bypass vs no bypass.
        for (int v = 0; v < 8; v++) begin
            idle_inputs();
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data; wr_be = vecs[v].wr_be;
            rd_en_a = vecs[v].rd_en_a; rd_addr_a = vecs[v].rd_addr_a;
            rd_en_b = vecs[v].rd_en_b; rd_addr_b = vecs[v].rd_addr_b;
            cycle();
            check($sformatf("vec%0d.valid_a", v), 32'(rd_valid_a[0]), 32'(vecs[v].exp_va));
            check($sformatf("vec%0d.valid_b", v), 32'(rd_valid_b[1]), 32'(vecs[v].exp_vb));
            check($sformatf("vec%0d.d0_a", v), 32'(rd_data_a[0]), 32'(vecs[v].exp_a0));
            check($sformatf("vec%0d.d0_b", v), 32'(rd_data_b[0]), 32'(vecs[v].exp_b0));
            check($sformatf("vec%0d.d1_a", v), 32'(rd_data_a[1]), 32'(vecs[v].exp_a1));
            check($sformatf("vec%0d.d1_b", v), 32'(rd_data_b[1]), 32'(vecs[v].exp_b1));
        end

        // Out-of-range on the 6-deep instance: read 7, then write 6.
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 3'd7;
        cycle();
        check("oor_rd.err", 32'(addr_err[1]), 32'd1);
        check("oor_rd.data", 32'(rd_data_a[1]), 32'd0);
        check("oor_rd.valid", 32'(rd_valid_a[1]), 32'd1);
        check("oor_rd.err_d0", 32'(addr_err[0]), 32'd0);
        idle_inputs();
        cycle();
        check("oor_rd.err_drop", 32'(addr_err[1]), 32'd0);
        do_write(6, 16'h5A5A);
        check("oor_wr.err", 32'(addr_err[1]), 32'd1);
        idle_inputs();
        cycle();
        check("oor_wr.err_drop", 32'(addr_err[1]), 32'd0);
        do_read(6);
        check("oor_wr.d0_written", 32'(rd_data_a[0]), 32'h5A5A);

        // Bulk clear with a dropped write, a mid-clear read and an ignored re-request.
        for (int i = 0; i < 8; i++) do_write(i, 16'h1000 + 16'(i) * 16'h0111);
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        for (int d = 0; d < NDUT; d++) busy_cnt[d] = int'(busy[d]);
        for (int j = 1; j < 20; j++) begin
            idle_inputs();
            if (j == 3) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hDEAD; wr_be = 2'b11; end
            if (j == 4) begin rd_en_a = 1'b1; rd_addr_a = 3'd7; end
            if (j == 5) clr_req = 1'b1;
            cycle();
            if (j == 4) check("clr.read7_old", 32'(rd_data_a[0]), 32'h1777);
            for (int d = 0; d < NDUT; d++) busy_cnt[d] += int'(busy[d]);
        end
        check("clr.busy_len_d0", 32'(busy_cnt[0]), 32'd8);
        check("clr.busy_len_d1", 32'(busy_cnt[1]), 32'd6);
        for (int i = 0; i < 8; i++) begin
            do_read(i);
            check($sformatf("clr.zero%0d", i), 32'(rd_data_a[0]), 32'd0);
        end

        // Reset in the middle of a clear.
        for (int i = 0; i < 8; i++) do_write(i, 16'h2000 + 16'(i));
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_mid.busy_d0", 32'(busy[0]), 32'd0);
        check("rst_mid.busy_d1", 32'(busy[1]), 32'd0);
        check_outputs();
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_read(i);
            check($sformatf("rst_mid.zero%0d", i), 32'(rd_data_b[0]), 32'd0);
        end

        // Entry 0 under the zero-register option, including a same-cycle bypass.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
        rd_en_a = 1'b1; rd_addr_a = 3'd0;
        cycle();
        check("zr.bypass_d0", 32'(rd_data_a[0]), 32'hFFFF);
        check("zr.bypass_d1", 32'(rd_data_a[1]), 32'd0);
        do_read(0);
        check("zr.read_d0", 32'(rd_data_a[0]), 32'hFFFF);
        check("zr.read_d1", 32'(rd_data_a[1]), 32'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            wr_be     = 2'($urandom_range(0, 3));
            rd_en_a   = 1'($urandom_range(0, 1));
            rd_addr_a = ($urandom_range(0, 1) == 1) ? wr_addr : 3'($urandom_range(0, 7));
            rd_en_b   = 1'($urandom_range(0, 1));
            rd_addr_b = 3'($urandom_range(0, 7));
            clr_req   = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
